evt_counter_2d: RTL and testbench

- Parametrised successor to the single-axis modulo event counter: counts qualified events into an (x, y) position with independent runtime moduli per axis.
- Produces registered line-end and frame-end pulses, plus an optional saturate-and-hold frame mode.
- Sits in the camera path after pixel-valid qualification, supplying hcount/vcount-style coordinates and frame boundaries to downstream detection and BRAM addressing logic.

---
 rtl/evt_counter_2d.sv | 74 +++++++
 tb/tb_evt_counter_2d.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/evt_counter_2d.sv
// Purpose : counts qualified events into an (x, y) position with per-axis runtime moduli,
//           emitting registered line-end / frame-end pulses and an optional saturate-and-hold mode.
// Latency : 1 cycle from evt_in to updated x_out/y_out and pulses; full throughput, no backpressure
//           (events arriving while done_out is high, or alongside clr_in, are dropped).
// Ports   : clk_in, rst_in (async, active-high), clr_in (sync clear), evt_in (event strobe),
//           max_x_in / max_y_in (moduli, 0 = full range), saturate_in (hold after frame),
//           x_out / y_out (position), line_end_out / frame_end_out (pulses), done_out (held level).
module evt_counter_2d #(
  parameter int WIDTH_X = 11,
  parameter int WIDTH_Y = 10
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               clr_in,
  input  logic               evt_in,
  input  logic [WIDTH_X-1:0] max_x_in,
  input  logic [WIDTH_Y-1:0] max_y_in,
  input  logic               saturate_in,
  output logic [WIDTH_X-1:0] x_out,
  output logic [WIDTH_Y-1:0] y_out,
  output logic               line_end_out,
  output logic               frame_end_out,
  output logic               done_out
);

  // Terminal positions in axis width; a modulus of 0 wraps to all-ones, i.e. full range.
  logic [WIDTH_X-1:0] last_x;
  logic [WIDTH_Y-1:0] last_y;
  logic               accept;

  assign last_x = max_x_in - WIDTH_X'(1);
  assign last_y = max_y_in - WIDTH_Y'(1);
  assign accept = evt_in & ~done_out;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_out         <= '0;
      y_out         <= '0;
      line_end_out  <= 1'b0;
      frame_end_out <= 1'b0;
      done_out      <= 1'b0;
    end else if (clr_in) begin
      x_out         <= '0;
      y_out         <= '0;
      line_end_out  <= 1'b0;
      frame_end_out <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      line_end_out  <= 1'b0;
      frame_end_out <= 1'b0;
      if (accept) begin
        if (x_out < last_x) begin
          x_out <= x_out + WIDTH_X'(1);
        end else begin
          // >= rather than == so a modulus lowered below the current x still wraps.
          line_end_out <= 1'b1;
          if (y_out < last_y) begin
            x_out <= '0;
            y_out <= y_out + WIDTH_Y'(1);
          end else begin
            frame_end_out <= 1'b1;
            if (saturate_in) begin
              done_out <= 1'b1;
            end else begin
              x_out <= '0;
              y_out <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_evt_counter_2d.sv
// Purpose : self-checking bench for evt_counter_2d (default widths plus a 3-bit-x instance).
// Latency : expectations are queued when stimulus is driven and compared 1 cycle later.
// Ports   : none (top-level bench).
module tb_evt_counter_2d;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        evt;
  logic [10:0] max_x;
  logic [9:0]  max_y;
  logic        sat;
  logic [10:0] x;
  logic [9:0]  y;
  logic        le, fe, dn;

  // Narrow-x instance for the full-range (modulus 0) boundary.
  logic [2:0]  max_x_s;
  logic [9:0]  max_y_s;
  logic [2:0]  x_s;
  logic [9:0]  y_s;
  logic        le_s, fe_s, dn_s;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int x;
    int y;
    bit le;
    bit fe;
    bit dn;
  } exp_t;

  exp_t sb[$];

  // Reference state
  int m_x, m_y;
  bit m_done;

  always #5 clk = ~clk;

  evt_counter_2d dut (
    .clk_in(clk), .rst_in(rst), .clr_in(clr), .evt_in(evt),
    .max_x_in(max_x), .max_y_in(max_y), .saturate_in(sat),
    .x_out(x), .y_out(y), .line_end_out(le), .frame_end_out(fe), .done_out(dn)
  );

  evt_counter_2d #(.WIDTH_X(3), .WIDTH_Y(10)) dut_s (
    .clk_in(clk), .rst_in(rst), .clr_in(clr), .evt_in(evt),
    .max_x_in(max_x_s), .max_y_in(max_y_s), .saturate_in(1'b0),
    .x_out(x_s), .y_out(y_s), .line_end_out(le_s), .frame_end_out(fe_s), .done_out(dn_s)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected result, then compare after the edge.
  task automatic drive(input bit e, input bit c);
    exp_t ex;
    int   mx, my;
    @(negedge clk);
    evt = e;
    clr = c;
    ex.le = 1'b0;
    ex.fe = 1'b0;
    if (c) begin
      m_x = 0; m_y = 0; m_done = 1'b0;
    end else if (e && !m_done) begin
      mx = (max_x == 0) ? 2048 : int'(max_x);
      my = (max_y == 0) ? 1024 : int'(max_y);
      if (m_x < mx - 1) begin
        m_x++;
      end else begin
        ex.le = 1'b1;
        if (m_y < my - 1) begin
          m_x = 0;
          m_y++;
        end else begin
          ex.fe = 1'b1;
          if (sat) m_done = 1'b1;
          else begin
            m_x = 0; m_y = 0;
          end
        end
      end
    end
    ex.x  = m_x;
    ex.y  = m_y;
    ex.dn = m_done;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      ex = sb.pop_front();
      check("sb_x", int'(x), ex.x);
      check("sb_y", int'(y), ex.y);
      check("sb_line_end", int'(le), int'(ex.le));
      check("sb_frame_end", int'(fe), int'(ex.fe));
      check("sb_done", int'(dn), int'(ex.dn));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; evt = 1'b0;
    max_x = 11'd4; max_y = 10'd3; sat = 1'b0;
    max_x_s = 3'd0; max_y_s = 10'd0;
    m_x = 0; m_y = 0; m_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_le", int'(le), 0);
    check("rst_fe", int'(fe), 0);
    check("rst_done", int'(dn), 0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap mode, 4x3, 12 events
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0);
      check("wrap_seq_x", int'(x), (i + 1) % 4);
      check("wrap_seq_le", int'(le), ((i + 1) % 4 == 0) ? 1 : 0);
      check("wrap_seq_fe", int'(fe), (i == 11) ? 1 : 0);
    end
    check("wrap_end_y", int'(y), 0);
    drive(1'b0, 1'b0);

    // Saturate mode, 15 events then clear
    sat = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0);
      if (i == 11) begin
        check("sat_x", int'(x), 3);
        check("sat_y", int'(y), 2);
        check("sat_done", int'(dn), 1);
        check("sat_fe", int'(fe), 1);
      end
      if (i > 11) check("sat_hold_fe", int'(fe), 0);
    end
    drive(1'b0, 1'b1);
    check("sat_clr_done", int'(dn), 0);
    check("sat_clr_x", int'(x), 0);
    sat = 1'b0;

    // Gapped events, 2x2
    max_x = 11'd2; max_y = 10'd2;
    for (int i = 0; i < 8; i++) drive(~i[0], 1'b0);

    // Runtime modulus change: x=6 under max 8, then lower to 4
    drive(1'b0, 1'b1);
    max_x = 11'd8; max_y = 10'd3;
    repeat (6) drive(1'b1, 1'b0);
    check("modchg_pre_x", int'(x), 6);
    max_x = 11'd4;
    drive(1'b1, 1'b0);
    check("modchg_x", int'(x), 0);
    check("modchg_y", int'(y), 1);
    check("modchg_le", int'(le), 1);

    // Modulus 1 on both axes
    drive(1'b0, 1'b1);
    max_x = 11'd1; max_y = 10'd1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      check("m1_le", int'(le), 1);
      check("m1_fe", int'(fe), 1);
      check("m1_x", int'(x), 0);
    end

    // Modulus 0 on a 3-bit x: counts 0..7 then wraps
    drive(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      check("full_x", int'(x_s), (i + 1) % 8);
      check("full_le", int'(le_s), (i == 7) ? 1 : 0);
      check("full_y", int'(y_s), (i == 7) ? 1 : 0);
    end

    // clr with evt at x=3: clear wins, no pulse
    drive(1'b0, 1'b1);
    max_x = 11'd8; max_y = 10'd3;
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    check("clr_evt_x", int'(x), 0);
    check("clr_evt_y", int'(y), 0);
    check("clr_evt_le", int'(le), 0);

    // Asynchronous reset mid-frame
    repeat (2) drive(1'b1, 1'b0);
    @(negedge clk);
    evt = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_x", int'(x), 0);
    check("arst_y", int'(y), 0);
    check("arst_done", int'(dn), 0);
    m_x = 0; m_y = 0; m_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0);
    check("arst_resume_x", int'(x), 1);
    drive(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
